// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill controller with pipelined memory reads
module cache_fill_fsm #(
    parameter int WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        mem_grant,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        mem_ren,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  word_offset,
    output logic [15:0] array_wdata,
    output logic        write_tag_array
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    localparam logic [3:0] ISSUE_LIMIT = 4'(WORDS);
    localparam logic [2:0] LAST_WORD   = 3'(WORDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  recv_cnt_q, recv_cnt_d;
    logic [11:0] blk_addr_q, blk_addr_d;

    // Byte-within-word and word offset of the miss are irrelevant: the whole block is fetched.
    logic unused_miss_low;
    assign unused_miss_low = &{1'b0, miss_address[3:0]};

    always_comb begin
        state_d          = state_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        blk_addr_d       = blk_addr_q;
        fsm_busy         = 1'b0;
        mem_ren          = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        word_offset      = 3'd0;
        write_tag_array  = 1'b0;
        array_wdata      = memory_data;

        case (state_q)
            IDLE: begin
                // Stall starts in the miss cycle itself, before the grant is seen.
                fsm_busy = miss_detected;
                if (miss_detected && mem_grant) begin
                    blk_addr_d  = miss_address[15:4];
                    issue_cnt_d = 4'd0;
                    recv_cnt_d  = 3'd0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt_q < ISSUE_LIMIT) begin
                    mem_ren        = 1'b1;
                    memory_address = {blk_addr_q, issue_cnt_q[2:0], 1'b0};
                    issue_cnt_d    = issue_cnt_q + 4'd1;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    word_offset      = recv_cnt_q;
                    recv_cnt_d       = recv_cnt_q + 3'd1;
                    if (recv_cnt_q == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        issue_cnt_d     = 4'd0;
                        recv_cnt_d      = 3'd0;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= 4'd0;
            recv_cnt_q  <= 3'd0;
            blk_addr_q  <= 12'h000;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            blk_addr_q  <= blk_addr_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        mem_grant;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_ren;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_offset;
    logic [15:0] array_wdata;
    logic        write_tag_array;

    cache_fill_fsm #(.WORDS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .mem_grant         (mem_grant),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_ren           (mem_ren),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_offset       (word_offset),
        .array_wdata       (array_wdata),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        ren;
        logic [15:0] addr;
        logic        wda;
        logic [2:0]  off;
        logic [15:0] wdata;
        logic        tag;
    } ov_t;

    localparam int N   = 64;
    localparam int LAT = 4;

    int          n_vec;
    int          n_bad;
    int          cyc;
    logic [15:0] mem_seed;
    logic        ret_v [N];
    logic [15:0] ret_d [N];

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return mem_seed + 16'(a[3:1]);
    endfunction

    function automatic ov_t sample();
        ov_t o;
        o.busy  = fsm_busy;
        o.ren   = mem_ren;
        o.addr  = memory_address;
        o.wda   = write_data_array;
        o.off   = word_offset;
        o.wdata = array_wdata;
        o.tag   = write_tag_array;
        return o;
    endfunction

    // k is the cycle relative to the miss+grant cycle; the block fill is a fixed timeline.
    function automatic ov_t ref_out(input int k, input logic [15:0] a, input bit aborted,
                                    input logic miss, input logic [15:0] mdata);
        ov_t r;
        r       = '0;
        r.wdata = mdata;
        if (aborted || k > 12) begin
            r.busy = miss;
            return r;
        end
        r.busy = 1'b1;
        if (k >= 1 && k <= 8) begin
            r.ren  = 1'b1;
            r.addr = {a[15:4], 4'h0} + 16'((k - 1) * 2);
        end
        if (k >= 5) begin
            r.wda = 1'b1;
            r.off = 3'(k - 5);
        end
        r.tag = (k == 12);
        return r;
    endfunction

    task automatic mem_drive();
        int s;
        s = cyc % N;
        memory_data_valid = ret_v[s];
        memory_data       = ret_v[s] ? ret_d[s] : 16'($urandom);
        ret_v[s]          = 1'b0;
    endtask

    task automatic mem_record();
        int s;
        if (mem_ren === 1'b1) begin
            s        = (cyc + LAT) % N;
            ret_v[s] = 1'b1;
            ret_d[s] = memfn(memory_address);
        end
        cyc++;
    endtask

    task automatic run_fill(input string name, input logic [15:0] a, input int d,
                            input int rst_k, input bit noisy);
        ov_t e;
        ov_t o;
        for (int k = -d; k <= 12; k++) begin
            @(negedge clk);
            rst_n         = !(k == rst_k);
            miss_detected = (k <= 0) || (noisy && ($urandom_range(0, 1) == 1));
            miss_address  = (k <= 0) ? a : 16'($urandom);
            mem_grant     = (k == 0);
            mem_drive();
            #1;
            e = ref_out(k, a, (rst_k >= 0) && (k > rst_k), miss_detected, memory_data);
            o = sample();
            if (!e.wda) o.off = 3'd0;
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s k=%0d observed=%h expected=%h", name, k, o, e);
            end
            mem_record();
        end
        rst_n         = 1'b1;
        miss_detected = 1'b0;
        mem_grant     = 1'b0;
    endtask

    task automatic test_reset();
        ov_t e;
        ov_t o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_n         = (i == 2);
            miss_detected = 1'b0;
            mem_grant     = 1'b1;
            miss_address  = 16'($urandom);
            mem_drive();
            #1;
            e       = '0;
            e.wdata = memory_data;
            o       = sample();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset i=%0d observed=%h expected=%h", i, o, e);
            end
            mem_record();
        end
        mem_grant = 1'b0;
    endtask

    task automatic test_fill_basic();
        mem_seed = 16'hA000;
        run_fill("fill_basic", 16'h1234, 0, -1, 1'b0);
    endtask

    task automatic test_grant_delay();
        mem_seed = 16'hA000;
        run_fill("grant_delay", 16'h1234, 3, -1, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        mem_seed = 16'h5A00;
        run_fill("reset_mid_fill", 16'h2468, 0, 6, 1'b0);
    endtask

    task automatic test_back_to_back();
        mem_seed = 16'h1100;
        run_fill("b2b_first", 16'h0040, 0, -1, 1'b1);
        mem_seed = 16'h2200;
        run_fill("b2b_second", 16'h7FF8, 0, -1, 1'b0);
    endtask

    task automatic test_idle_valid();
        ov_t e;
        ov_t o;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            miss_detected     = 1'b0;
            mem_grant         = ($urandom_range(0, 1) == 1);
            miss_address      = 16'($urandom);
            memory_data_valid = ($urandom_range(0, 1) == 1);
            memory_data       = 16'($urandom);
            #1;
            e       = '0;
            e.wdata = memory_data;
            o       = sample();
            n_vec++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL idle_valid i=%0d observed=%h expected=%h", i, o, e);
            end
            cyc++;
        end
        mem_grant         = 1'b0;
        memory_data_valid = 1'b0;
    endtask

    task automatic test_boundary();
        mem_seed = 16'hBEE0;
        run_fill("boundary", 16'hFFFE, 1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            mem_seed = 16'($urandom);
            run_fill("random", 16'($urandom), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : -1,
                     ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        n_vec             = 0;
        n_bad             = 0;
        cyc               = 0;
        mem_seed          = 16'h0000;
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        mem_grant         = 1'b0;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;
        for (int i = 0; i < N; i++) begin
            ret_v[i] = 1'b0;
            ret_d[i] = 16'h0000;
        end
        test_reset();
        test_fill_basic();
        test_grant_delay();
        test_reset_mid_fill();
        test_back_to_back();
        test_idle_valid();
        test_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
